// File: rtl/cruise_ctrl_param.sv
// Parametrised cruise-control controller: manual / cruise / brake states,
// saturating speed model, clamped setpoint and a resume memory with valid flag.
module cruise_ctrl_param #(
    parameter int unsigned SPEED_W    = 8,
    parameter int unsigned SPEED_MAX  = 200,
    parameter int unsigned MIN_SET    = 46,
    parameter int unsigned ACCEL_STEP = 1,
    parameter int unsigned DECAY_STEP = 1,
    parameter int unsigned BRAKE_STEP = 2,
    parameter int unsigned TRACK_STEP = 1,
    parameter int unsigned SET_STEP   = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               throttle_i,
    input  logic               set_i,
    input  logic               accel_i,
    input  logic               coast_i,
    input  logic               cancel_i,
    input  logic               resume_i,
    input  logic               brake_i,
    output logic [SPEED_W-1:0] speed_o,
    output logic [SPEED_W-1:0] speedset_o,
    output logic               cruisecontrol_o,
    output logic [1:0]         state_o,
    output logic               mem_valid_o
);

    localparam logic [SPEED_W-1:0] SpeedMax  = SPEED_W'(SPEED_MAX);
    localparam logic [SPEED_W-1:0] MinSet    = SPEED_W'(MIN_SET);
    localparam logic [SPEED_W-1:0] AccelStep = SPEED_W'(ACCEL_STEP);
    localparam logic [SPEED_W-1:0] DecayStep = SPEED_W'(DECAY_STEP);
    localparam logic [SPEED_W-1:0] BrakeStep = SPEED_W'(BRAKE_STEP);
    localparam logic [SPEED_W-1:0] TrackStep = SPEED_W'(TRACK_STEP);
    localparam logic [SPEED_W-1:0] SetStep   = SPEED_W'(SET_STEP);

    typedef enum logic [1:0] {
        StManu  = 2'd0,
        StAuto  = 2'd1,
        StBrake = 2'd2
    } state_e;

    state_e             state_q;
    logic [SPEED_W-1:0] speed_q;
    logic [SPEED_W-1:0] speedset_q;
    logic [SPEED_W-1:0] cruisespeed_q;
    logic               mem_valid_q;

    // min(x + k, SpeedMax), summed with a guard bit so it never wraps
    function automatic logic [SPEED_W-1:0] sat_add(input logic [SPEED_W-1:0] x,
                                                   input logic [SPEED_W-1:0] k);
        logic [SPEED_W:0] sum;
        sum = {1'b0, x} + {1'b0, k};
        return (sum > {1'b0, SpeedMax}) ? SpeedMax : sum[SPEED_W-1:0];
    endfunction

    // max(x - k, 0)
    function automatic logic [SPEED_W-1:0] sat_sub(input logic [SPEED_W-1:0] x,
                                                   input logic [SPEED_W-1:0] k);
        return (x < k) ? '0 : x - k;
    endfunction

    // Step toward the target by at most TrackStep without overshooting it
    function automatic logic [SPEED_W-1:0] track(input logic [SPEED_W-1:0] x,
                                                 input logic [SPEED_W-1:0] tgt);
        logic [SPEED_W-1:0] diff;
        if (x > tgt) begin
            diff = x - tgt;
            return x - ((diff < TrackStep) ? diff : TrackStep);
        end else if (x < tgt) begin
            diff = tgt - x;
            return x + ((diff < TrackStep) ? diff : TrackStep);
        end
        return x;
    endfunction

    // max(x - SetStep, MinSet), compared with a guard bit
    function automatic logic [SPEED_W-1:0] coast_set(input logic [SPEED_W-1:0] x);
        logic [SPEED_W:0] floor_sum;
        floor_sum = {1'b0, MinSet} + {1'b0, SetStep};
        return ({1'b0, x} < floor_sum) ? MinSet : x - SetStep;
    endfunction

    // Whole controller: state, speed model, setpoint and resume memory in one register stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StManu;
            speed_q       <= '0;
            speedset_q    <= '0;
            cruisespeed_q <= '0;
            mem_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                StManu: begin
                    if (brake_i) begin
                        state_q <= StBrake;
                        speed_q <= sat_sub(speed_q, BrakeStep);
                    end else begin
                        speed_q <= throttle_i ? sat_add(speed_q, AccelStep)
                                              : sat_sub(speed_q, DecayStep);
                        if (set_i && (speed_q >= MinSet)) begin
                            state_q    <= StAuto;
                            speedset_q <= speed_q;
                        end else if (resume_i && mem_valid_q && (speed_q != '0)) begin
                            state_q    <= StAuto;
                            speedset_q <= cruisespeed_q;
                        end
                    end
                end
                StAuto: begin
                    if (brake_i) begin
                        state_q       <= StBrake;
                        cruisespeed_q <= speedset_q;
                        mem_valid_q   <= 1'b1;
                        speed_q       <= sat_sub(speed_q, BrakeStep);
                    end else if (cancel_i) begin
                        state_q       <= StManu;
                        cruisespeed_q <= speedset_q;
                        mem_valid_q   <= 1'b1;
                        speed_q       <= sat_sub(speed_q, DecayStep);
                    end else begin
                        // Tracking uses the setpoint from before this cycle's accel/coast
                        speed_q <= throttle_i ? sat_add(speed_q, AccelStep)
                                              : track(speed_q, speedset_q);
                        if (accel_i && !coast_i) begin
                            speedset_q <= sat_add(speedset_q, SetStep);
                        end else if (coast_i && !accel_i) begin
                            speedset_q <= coast_set(speedset_q);
                        end
                    end
                end
                StBrake: begin
                    if (throttle_i) begin
                        state_q <= StManu;
                        speed_q <= sat_add(speed_q, AccelStep);
                    end else begin
                        speed_q <= sat_sub(speed_q, BrakeStep);
                        if (brake_i) begin
                            state_q <= StBrake;
                        end else if (set_i && (speed_q >= MinSet)) begin
                            state_q    <= StAuto;
                            speedset_q <= speed_q;
                        end else if (resume_i && mem_valid_q && (speed_q != '0)) begin
                            state_q    <= StAuto;
                            speedset_q <= cruisespeed_q;
                        end
                    end
                end
                default: begin
                    // Illegal encoding: recover to manual with speed frozen
                    state_q <= StManu;
                end
            endcase
        end
    end

    // Outputs are straight views of the registers
    always_comb begin
        speed_o         = speed_q;
        speedset_o      = speedset_q;
        state_o         = state_q;
        cruisecontrol_o = (state_q == StAuto);
        mem_valid_o     = mem_valid_q;
    end

endmodule

// File: tb/tb_cruise_ctrl_param.sv
// Scoreboard bench for cruise_ctrl_param: stimulus queues hand-computed expectations,
// a monitor pops and compares them one cycle at a time.
module tb_cruise_ctrl_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       throttle, set, accel, coast, cancel, resume, brake;
    logic [7:0] speed, speedset;
    logic       cruisecontrol, mem_valid;
    logic [1:0] state;

    cruise_ctrl_param dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .throttle_i     (throttle),
        .set_i          (set),
        .accel_i        (accel),
        .coast_i        (coast),
        .cancel_i       (cancel),
        .resume_i       (resume),
        .brake_i        (brake),
        .speed_o        (speed),
        .speedset_o     (speedset),
        .cruisecontrol_o(cruisecontrol),
        .state_o        (state),
        .mem_valid_o    (mem_valid)
    );

    always #5 clk = ~clk;

    // Input bundle order: {throttle, set, accel, coast, cancel, resume, brake}
    localparam logic [6:0] N = 7'b0000000;
    localparam logic [6:0] T = 7'b1000000;
    localparam logic [6:0] S = 7'b0100000;
    localparam logic [6:0] A = 7'b0010000;
    localparam logic [6:0] C = 7'b0001000;
    localparam logic [6:0] X = 7'b0000100;
    localparam logic [6:0] R = 7'b0000010;
    localparam logic [6:0] B = 7'b0000001;

    // -1 in a field means "don't check"
    typedef struct {
        int    cyc;
        int    sp;
        int    ss;
        int    st;
        int    mv;
        string nm;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic cmp(input string nm, input string fld, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s @cyc %0d: got %0d, expected %0d", nm, fld, cyc, act, exp);
        end
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d was skipped", e.nm, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            if (e.sp >= 0) cmp(e.nm, "speed", int'(speed), e.sp);
            if (e.ss >= 0) cmp(e.nm, "speedset", int'(speedset), e.ss);
            if (e.st >= 0) begin
                cmp(e.nm, "state", int'(state), e.st);
                cmp(e.nm, "cruisecontrol", int'(cruisecontrol), (e.st == 1) ? 1 : 0);
            end
            if (e.mv >= 0) cmp(e.nm, "mem_valid", int'(mem_valid), e.mv);
        end
    end

    // Drive one cycle of inputs and queue what the following edge must produce
    task automatic step(input logic r, input logic [6:0] in, input int sp, input int ss,
                        input int st, input int mv, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        {throttle, set, accel, coast, cancel, resume, brake} = in;
        e.cyc = cyc + 1;
        e.sp  = sp;
        e.ss  = ss;
        e.st  = st;
        e.mv  = mv;
        e.nm  = nm;
        q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        {throttle, set, accel, coast, cancel, resume, brake} = N;

        repeat (3) step(1'b0, N, 0, 0, 0, 0, "reset");
        for (int i = 1; i <= 10; i++) step(1'b1, T, i, 0, 0, 0, "ramp0");
        step(1'b0, T, 0, 0, 0, 0, "mid_reset");
        for (int i = 1; i <= 50; i++) step(1'b1, T, i, 0, 0, 0, "ramp");
        step(1'b1, N, 49, 0, 0, 0, "decay");
        step(1'b1, T, 50, 0, 0, 0, "ramp50");

        // Engage at 50; speed decays in the transition cycle
        step(1'b1, S, 49, 50, 1, 0, "set50");
        for (int i = 0; i < 5; i++) step(1'b1, T, 50 + i, 50, 1, 0, "auto_thr");
        for (int i = 1; i <= 4; i++) step(1'b1, N, 54 - i, 50, 1, 0, "track_dn");
        repeat (2) step(1'b1, N, 50, 50, 1, 0, "track_hold");

        // Setpoint walk to the ceiling; speed trails by one
        for (int n = 1; n <= 148; n++) step(1'b1, A, 49 + n, 50 + n, 1, 0, "accel");
        step(1'b1, A, 198, 199, 1, 0, "accel_hi");
        step(1'b1, A, 199, 200, 1, 0, "accel_max");
        repeat (3) step(1'b1, A, 200, 200, 1, 0, "set_sat");

        step(1'b1, X, 199, 200, 0, 1, "cancel");
        repeat (3) step(1'b1, T, 200, 200, 0, 1, "man_sat");

        for (int n = 1; n <= 70; n++) step(1'b1, B, 200 - 2 * n, 200, 2, 1, "brake_dn");
        step(1'b1, S, 58, 60, 1, 1, "set60");
        step(1'b1, N, 59, 60, 1, 1, "track_up");
        step(1'b1, N, 60, 60, 1, 1, "track_up");
        step(1'b1, N, 60, 60, 1, 1, "track_eq");

        step(1'b1, B, 58, 60, 2, 1, "auto_brake");
        step(1'b1, B, 56, 60, 2, 1, "brake_hold");
        step(1'b1, B | R, 54, 60, 2, 1, "brake_res");
        step(1'b1, R, 52, 60, 1, 1, "resume");
        for (int i = 53; i <= 55; i++) step(1'b1, N, i, 60, 1, 1, "res_track");

        step(1'b1, A | C, 56, 60, 1, 1, "acc_coast");
        step(1'b1, C, 57, 59, 1, 1, "coast");
        step(1'b1, X | B, 55, 59, 2, 1, "cancel_brake");

        for (int n = 1; n <= 27; n++) step(1'b1, B, 55 - 2 * n, 59, 2, 1, "brake_low");
        step(1'b1, B, 0, 59, 2, 1, "brake_zero");
        step(1'b1, B, 0, 59, 2, 1, "brake_zero");
        step(1'b1, R, 0, 59, 2, 1, "res_zero");

        // Fresh reset: resume without memory and the MIN_SET boundary
        step(1'b0, N, 0, 0, 0, 0, "reset2");
        for (int i = 1; i <= 30; i++) step(1'b1, T, i, 0, 0, 0, "ramp2");
        step(1'b1, R | T, 31, 0, 0, 0, "res_guard");
        for (int i = 32; i <= 45; i++) step(1'b1, T, i, 0, 0, 0, "ramp3");
        step(1'b1, S | T, 46, 0, 0, 0, "set45");
        step(1'b1, S, 45, 46, 1, 0, "set46");
        step(1'b1, C, 46, 46, 1, 0, "coast_clamp");

        @(negedge clk);
        {throttle, set, accel, coast, cancel, resume, brake} = N;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
